// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage downstream of the ALU. Non-memory ops and misaligned
//   lw/sw are retired in one cycle. Aligned lw/sw go out on a req/ack data
//   memory port and stall upstream until ack or timeout.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_*              upstream packet (valid/ready handshake)
//   mem_*             data-memory request port (registered req/we/addr/wdata)
//   wb_*              registered one-cycle writeback packet to the RF
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_aluop,
  input  logic [31:0] in_result,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_rwe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  localparam logic [5:0]       OP_LW   = 6'b001100;
  localparam logic [5:0]       OP_SW   = 6'b001101;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic             rwe_q;

  logic accept, is_mem, misal, start_mem, ack_done, to_done;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign is_mem    = (in_aluop == OP_LW) || (in_aluop == OP_SW);
  assign misal     = |in_result[1:0];
  assign start_mem = accept && is_mem && !misal;
  // ack wins over timeout when both land on the same cycle
  assign ack_done  = (state == BUSY) && mem_ack;
  assign to_done   = (state == BUSY) && !mem_ack && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_mem)           state_nxt = BUSY;
      BUSY: if (ack_done || to_done) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_err    <= 1'b0;
      cnt       <= '0;
      rd_q      <= '0;
      rwe_q     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (state == IDLE) begin
        if (start_mem) begin
          mem_req   <= 1'b1;
          mem_we    <= (in_aluop == OP_SW);
          mem_addr  <= in_result;
          mem_wdata <= in_wdata;
          rd_q      <= in_rd;
          rwe_q     <= in_rwe;
          cnt       <= '0;
        end else if (accept) begin
          // pass-through, or misaligned lw/sw reported as a fault
          wb_valid <= 1'b1;
          wb_data  <= in_result;
          wb_rd    <= in_rd;
          wb_err   <= is_mem;
          wb_we    <= !is_mem && in_rwe && (in_rd != 5'd0);
        end
      end else begin
        if (ack_done) begin
          mem_req  <= 1'b0;
          wb_valid <= 1'b1;
          wb_err   <= 1'b0;
          wb_rd    <= rd_q;
          // mem_we still holds the store flag of this access
          wb_we    <= !mem_we && rwe_q && (rd_q != 5'd0);
          wb_data  <= mem_we ? 32'd0 : mem_rdata;
        end else if (to_done) begin
          mem_req  <= 1'b0;
          wb_valid <= 1'b1;
          wb_err   <= 1'b1;
          wb_we    <= 1'b0;
          wb_rd    <= rd_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam logic [5:0] OP_LW = 6'b001100;
  localparam logic [5:0] OP_SW = 6'b001101;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_aluop;
  logic [31:0] in_result, in_wdata;
  logic [4:0]  in_rd;
  logic        in_rwe;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_valid, wb_we, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_access_stage #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_result(in_result), .in_wdata(in_wdata), .in_rd(in_rd), .in_rwe(in_rwe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rwe;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // scoreboard: every wb pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb_valid", wb_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_we", wb_we, e.we);
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_err", wb_err, e.err);
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end
  end

  // delay == 0 means the memory never acks (timeout path)
  task automatic do_mem(input logic sw, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rwe, input int delay,
                        input logic [31:0] rdata);
    exp_t e;
    int   cyc;
    if (delay == 0)  e = '{1'b0, rd, 32'd0, 1'b1, 1'b0};
    else if (sw)     e = '{1'b0, rd, 32'd0, 1'b0, 1'b1};
    else             e = '{rwe && (rd != 5'd0), rd, rdata, 1'b0, 1'b1};
    @(posedge clk); #1;
    in_valid = 1'b1; in_aluop = sw ? OP_SW : OP_LW;
    in_result = addr; in_wdata = wd; in_rd = rd; in_rwe = rwe;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = (delay == 0) ? 4 : delay;
    for (int k = 1; k <= cyc; k++) begin
      @(negedge clk);
      chk("busy_mem_req", mem_req, 1'b1);
      chk("busy_in_ready", in_ready, 1'b0);
      chk("busy_mem_addr", mem_addr, addr);
      chk("busy_mem_we", mem_we, sw);
      if (sw) chk("busy_mem_wdata", mem_wdata, wd);
      if (k == cyc && delay != 0) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    chk("done_mem_req", mem_req, 1'b0);
    chk("done_in_ready", in_ready, 1'b1);
    chk("done_wb_valid", wb_valid, 1'b1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{6'b000001, 32'h0000_0005, 5'd3,  1'b1, 1'b1, 1'b0};
    vecs[1] = '{6'b000001, 32'h0000_0005, 5'd3,  1'b1, 1'b1, 1'b0};
    vecs[2] = '{6'b000001, 32'h0000_0005, 5'd3,  1'b1, 1'b1, 1'b0};
    vecs[3] = '{6'b000010, 32'hCAFE_0001, 5'd0,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{6'b000011, 32'h0000_00FF, 5'd9,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_LW,     32'h0000_0013, 5'd4,  1'b1, 1'b0, 1'b1};
    vecs[6] = '{OP_SW,     32'h0000_0022, 5'd5,  1'b1, 1'b0, 1'b1};
    vecs[7] = '{6'b001110, 32'h0000_0003, 5'd31, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_aluop = '0; in_result = '0; in_wdata = '0;
    in_rd = '0; in_rwe = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;

    // single-cycle ops, back to back
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_aluop = vecs[i].op; in_result = vecs[i].res;
      in_wdata = 32'hFFFF_FFFF; in_rd = vecs[i].rd; in_rwe = vecs[i].rwe;
      exp_q.push_back('{vecs[i].exp_we, vecs[i].rd, vecs[i].res, vecs[i].exp_err, 1'b1});
      @(negedge clk);
      chk("vec_in_ready", in_ready, 1'b1);
      chk("vec_mem_req", mem_req, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("vec_last_wb_valid", wb_valid, 1'b1);
    chk("vec_mem_req_after", mem_req, 1'b0);

    do_mem(1'b0, 32'h0000_0010, 32'd0, 5'd7, 1'b1, 3, 32'hDEAD_BEEF);
    do_mem(1'b1, 32'h0000_0020, 32'h1234_5678, 5'd2, 1'b1, 1, 32'h0);
    do_mem(1'b0, 32'h0000_0040, 32'd0, 5'd0, 1'b1, 2, 32'hA5A5_5A5A);
    do_mem(1'b0, 32'h0000_0044, 32'd0, 5'd12, 1'b0, 1, 32'h0BAD_F00D);

    // timeout, then a late ack must be ignored
    do_mem(1'b0, 32'h0000_0080, 32'd0, 5'd6, 1'b1, 0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("late_ack_wb_valid", wb_valid, 1'b0);
      chk("late_ack_in_ready", in_ready, 1'b1);
    end

    // reset in the middle of an access
    @(posedge clk); #1;
    in_valid = 1'b1; in_aluop = OP_LW; in_result = 32'h0000_0100; in_rd = 5'd8; in_rwe = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", mem_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_wb_valid", wb_valid, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("post_rst_ack_wb_valid", wb_valid, 1'b0);
    end

    // after recovery a pass-through still works
    @(posedge clk); #1;
    in_valid = 1'b1; in_aluop = 6'b000001; in_result = 32'h0000_0777; in_rd = 5'd1; in_rwe = 1'b1;
    exp_q.push_back('{1'b1, 5'd1, 32'h0000_0777, 1'b0, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("recover_wb_valid", wb_valid, 1'b1);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
